// File: rtl/spike_pipe_pkg.sv
// Shared types and defaults for the waveform-to-pipe capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a. WAVEFORM_TO_PIPE_TIMESTAMP_EN adds a 16-bit sample index word.
package spike_pipe_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_BLOCK_WORDS = 256;

`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
    // Index word, low half, high half.
    localparam int WORDS_PER_SAMPLE = 3;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_WR_TS = 2'd3
    } wr_state_t;
`else
    localparam int WORDS_PER_SAMPLE = 2;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } wr_state_t;
`endif

endpackage

// File: rtl/waveform_to_pipe_if.sv
// Host-side pipe-out bundle: read strobe, data word, level and status flags.
// Latency: n/a (wires only).
// Backpressure: host pulls words with ep_read; ep_ready advertises a full block.
interface waveform_to_pipe_if #(
    parameter int FILL_W = 11
);
    logic              ep_read;
    logic [15:0]       ep_datain;
    logic              ep_ready;
    logic [FILL_W-1:0] fill_words;
    logic              overflow;
    logic              underflow;

    // Capture block side: drives data and status, consumes the read strobe.
    modport master (
        input  ep_read,
        output ep_datain, ep_ready, fill_words, overflow, underflow
    );

    // Host side.
    modport slave (
        output ep_read,
        input  ep_datain, ep_ready, fill_words, overflow, underflow
    );
endinterface

// File: rtl/waveform_to_pipe_sync_edge_detect.sv
// Two-flop synchronizer for a foreign-domain level plus rising-edge pulse.
// Latency: pulse is high in the cycle after the second synchronizer flop sees the edge.
// Backpressure: none; pulse is a single clk cycle wide per rising edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    // Shift the async level through the synchronizer and keep one delayed copy.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/waveform_to_pipe.sv
// Captures 32-bit samples on slow test_clk edges into a 16-bit FIFO drained by a block pipe.
// Latency: ~3 ti_clk from test_clk edge to capture, then one word per cycle; ep_ready lags fill by 1.
// Backpressure: a sample is dropped whole (overflow) if space is short or a write is in flight. Macro: WAVEFORM_TO_PIPE_TIMESTAMP_EN.
module waveform_to_pipe
    import spike_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic                  ti_clk,
    input  logic                  reset_global,
    input  logic                  repop,
    input  logic                  test_clk,
    input  logic                  capture_en,
    input  logic [31:0]           sample_in,
    waveform_to_pipe_if.master    pipe
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] DEPTH_FW = FW'(DEPTH_WORDS);
    localparam logic [FW-1:0] BLOCK_FW = FW'(BLOCK_WORDS);
    localparam logic [FW-1:0] WPS_FW   = FW'(WORDS_PER_SAMPLE);

    logic cap_pulse;

    wr_state_t       state_q, state_d;
    logic [31:0]     hold_q, hold_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            rdy_q, rdy_d;
    logic            byp_q, byp_d;
    logic [15:0]     byp_dat_q, byp_dat_d;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
    logic [15:0]     ts_q, ts_d;
`endif

    logic            wr_en;
    logic [15:0]     wr_dat;
    logic            rd_ok;
    logic            cap_req;
    logic            space_ok;

    logic [15:0]     mem [DEPTH_WORDS];
    logic [15:0]     ram_rd_q;

    sync_edge_detect u_test_clk_edge (
        .clk      (ti_clk),
        .rst      (reset_global),
        .async_in (test_clk),
        .pulse    (cap_pulse)
    );

    assign cap_req  = cap_pulse & capture_en;
    // Space is checked up front so a sample is either written whole or not at all;
    // only reads can change fill while the FSM is idle, and they only free space.
    assign space_ok = (DEPTH_FW - fill_q) >= WPS_FW;
    assign rd_ok    = pipe.ep_read & (fill_q != '0);

    // Write FSM: accept a capture, then emit its words one per cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_dat  = 16'h0000;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
        ts_d    = ts_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cap_req) begin
                    if (space_ok) begin
                        hold_d = sample_in;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
                        state_d = ST_WR_TS;
`else
                        state_d = ST_WR_LO;
`endif
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
            ST_WR_TS: begin
                wr_en   = 1'b1;
                wr_dat  = ts_q;
                ts_d    = ts_q + 16'd1;
                state_d = ST_WR_LO;
                if (cap_req) ovf_d = 1'b1;
            end
`endif
            ST_WR_LO: begin
                wr_en   = 1'b1;
                wr_dat  = hold_q[15:0];
                state_d = ST_WR_HI;
                if (cap_req) ovf_d = 1'b1;
            end
            ST_WR_HI: begin
                wr_en   = 1'b1;
                wr_dat  = hold_q[31:16];
                state_d = ST_IDLE;
                if (cap_req) ovf_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // repop wins over anything else happening this cycle.
        if (repop) begin
            state_d = ST_IDLE;
            hold_d  = hold_q;
            ovf_d   = 1'b0;
            wr_en   = 1'b0;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
            ts_d    = 16'd0;
`endif
        end
    end

    // Pointers, occupancy, underflow, ready and the write-to-read bypass.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(rd_ok);
        fill_d    = fill_q + FW'(wr_en) - FW'(rd_ok);
        unf_d     = unf_q | (pipe.ep_read & (fill_q == '0));
        rdy_d     = fill_q >= BLOCK_FW;
        // The RAM read port cannot see a word written on the same edge, so
        // capture it separately when it lands where the read pointer will be.
        byp_d     = wr_en & (wr_ptr_q == rd_ptr_d);
        byp_dat_d = wr_dat;
        if (repop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            unf_d    = 1'b0;
            byp_d    = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            state_q   <= ST_IDLE;
            hold_q    <= 32'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rdy_q     <= 1'b0;
            byp_q     <= 1'b0;
            byp_dat_q <= 16'h0;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
            ts_q      <= 16'h0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rdy_q     <= rdy_d;
            byp_q     <= byp_d;
            byp_dat_q <= byp_dat_d;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    // Simple dual-port RAM; contents are never reset, fill gating hides stale words.
    always_ff @(posedge ti_clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_dat;
        ram_rd_q <= mem[rd_ptr_d];
    end

    assign pipe.ep_datain  = (fill_q == '0) ? 16'h0000 : (byp_q ? byp_dat_q : ram_rd_q);
    assign pipe.ep_ready   = rdy_q;
    assign pipe.fill_words = fill_q;
    assign pipe.overflow   = ovf_q;
    assign pipe.underflow  = unf_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Directed bench for waveform_to_pipe with a word scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_waveform_to_pipe;
    import spike_pipe_pkg::*;

    localparam int DEPTH = 1024;
    localparam int BLOCK = 256;
    localparam int FW    = 11;
    localparam int WPS   = WORDS_PER_SAMPLE;

    logic        ti_clk       = 1'b0;
    logic        reset_global = 1'b1;
    logic        repop        = 1'b0;
    logic        test_clk     = 1'b0;
    logic        capture_en   = 1'b0;
    logic [31:0] sample_in    = 32'h0;

    waveform_to_pipe_if #(.FILL_W(FW)) pipe ();

    waveform_to_pipe #(.DEPTH_WORDS(DEPTH), .BLOCK_WORDS(BLOCK)) dut (
        .ti_clk       (ti_clk),
        .reset_global (reset_global),
        .repop        (repop),
        .test_clk     (test_clk),
        .capture_en   (capture_en),
        .sample_in    (sample_in),
        .pipe         (pipe)
    );

    always #5 ti_clk = ~ti_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q[$];
    logic [15:0] exp_ts   = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; ep_ready must reflect the previous cycle's fill.
    task automatic tick();
        logic [FW-1:0] pf;
        pf = pipe.fill_words;
        @(negedge ti_clk);
        chk("ep_ready_lag", {31'h0, pipe.ep_ready}, {31'h0, (pf >= FW'(BLOCK))});
    endtask

    task automatic push_sample(input logic [31:0] v);
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
        q.push_back(exp_ts);
        exp_ts = exp_ts + 16'd1;
`endif
        q.push_back(v[15:0]);
        q.push_back(v[31:16]);
    endtask

    task automatic capture(input logic [31:0] v, input bit accept);
        sample_in = v;
        test_clk  = 1'b1;
        repeat (4) tick();
        test_clk  = 1'b0;
        repeat (4) tick();
        if (accept) push_sample(v);
    endtask

    task automatic rd_chk(input string tag);
        logic [31:0] e;
        e = (q.size() != 0) ? {16'h0, q.pop_front()} : 32'hDEAD_BEEF;
        chk(tag, {16'h0, pipe.ep_datain}, e);
        pipe.ep_read = 1'b1;
        tick();
        pipe.ep_read = 1'b0;
    endtask

    task automatic do_repop();
        repop = 1'b1;
        tick();
        repop = 1'b0;
        q.delete();
        exp_ts = 16'h0;
    endtask

    task automatic chk_idle(input string pfx);
        chk($sformatf("%s_datain", pfx),    {16'h0, pipe.ep_datain},   32'h0);
        chk($sformatf("%s_ready", pfx),     {31'h0, pipe.ep_ready},    32'h0);
        chk($sformatf("%s_fill", pfx),      {21'h0, pipe.fill_words},  32'h0);
        chk($sformatf("%s_overflow", pfx),  {31'h0, pipe.overflow},    32'h0);
        chk($sformatf("%s_underflow", pfx), {31'h0, pipe.underflow},   32'h0);
    endtask

    initial begin
        int          nblk;
        int          nfull;
        bit          found;
        logic [31:0] v;
        logic [31:0] e;

        pipe.ep_read = 1'b0;

        // Reset state.
        repeat (3) @(negedge ti_clk);
        chk_idle("reset");
        reset_global = 1'b0;
        tick();
        capture_en = 1'b1;

        // Single sample, read back low then high half.
        capture(32'h3F80_0000, 1'b1);
        chk("single_fill", {21'h0, pipe.fill_words}, WPS);
        for (int i = 0; i < WPS; i++) rd_chk("single_word");
        chk("single_drain", {21'h0, pipe.fill_words}, 32'h0);

        // capture_en low: nothing captured.
        capture_en = 1'b0;
        capture(32'h1234_5678, 1'b0);
        chk("cap_en_low_fill", {21'h0, pipe.fill_words}, 32'h0);
        capture_en = 1'b1;

        // Read from empty FIFO.
        pipe.ep_read = 1'b1;
        tick();
        pipe.ep_read = 1'b0;
        chk("empty_rd_datain", {16'h0, pipe.ep_datain}, 32'h0);
        chk("underflow_set", {31'h0, pipe.underflow}, 32'h1);
        chk("empty_rd_fill", {21'h0, pipe.fill_words}, 32'h0);
        do_repop();
        chk("repop_underflow", {31'h0, pipe.underflow}, 32'h0);

        // One block of data; ep_ready follows fill one cycle late.
        nblk = (BLOCK + WPS - 1) / WPS;
        for (int i = 0; i < nblk; i++) capture({16'hC000 + 16'(i), 16'(i * 37)}, 1'b1);
        chk("blk_fill", {21'h0, pipe.fill_words}, nblk * WPS);
        chk("blk_ready", {31'h0, pipe.ep_ready}, 32'h1);
        for (int i = 0; i < BLOCK; i++) rd_chk("blk_word");
        tick();
        chk("blk_ready_fall", {31'h0, pipe.ep_ready}, 32'h0);
        while (q.size() != 0) rd_chk("blk_tail");
        chk("blk_drain", {21'h0, pipe.fill_words}, 32'h0);

        // Fill to capacity, then one more sample is dropped whole.
        nfull = DEPTH / WPS;
        for (int i = 0; i < nfull; i++) capture($urandom, 1'b1);
        chk("full_fill", {21'h0, pipe.fill_words}, nfull * WPS);
        chk("full_no_ovf", {31'h0, pipe.overflow}, 32'h0);
        capture(32'hFFFF_0000, 1'b0);
        chk("ovf_fill_kept", {21'h0, pipe.fill_words}, nfull * WPS);
        chk("ovf_set", {31'h0, pipe.overflow}, 32'h1);
        for (int i = 0; i < 8; i++) rd_chk("full_word");
        chk("ovf_sticky", {31'h0, pipe.overflow}, 32'h1);
        do_repop();
        chk("repop_ovf", {31'h0, pipe.overflow}, 32'h0);
        chk("repop_fill", {21'h0, pipe.fill_words}, 32'h0);
        chk("repop_datain", {16'h0, pipe.ep_datain}, 32'h0);

        // Second edge while a sample is being written is dropped.
        sample_in = 32'hABCD_1234;
        test_clk  = 1'b1;
        tick();
        test_clk  = 1'b0;
        tick();
        test_clk  = 1'b1;
        tick();
        sample_in = 32'h5555_AAAA;
        repeat (3) tick();
        test_clk  = 1'b0;
        repeat (4) tick();
        push_sample(32'hABCD_1234);
        chk("busy_drop_fill", {21'h0, pipe.fill_words}, WPS);
        chk("busy_drop_ovf", {31'h0, pipe.overflow}, 32'h1);
        for (int i = 0; i < WPS; i++) rd_chk("busy_drop_word");
        do_repop();

        // Streaming: a capture every 8 cycles, read whenever data is present.
        for (int cyc = 0; cyc < 24 * 8; cyc++) begin
            if (cyc % 8 == 0) begin
                v         = $urandom;
                sample_in = v;
                test_clk  = 1'b1;
                push_sample(v);
            end
            if (cyc % 8 == 4) test_clk = 1'b0;
            if (pipe.fill_words != '0) begin
                e = (q.size() != 0) ? {16'h0, q.pop_front()} : 32'hDEAD_BEEF;
                chk("stream_word", {16'h0, pipe.ep_datain}, e);
                pipe.ep_read = 1'b1;
            end else begin
                pipe.ep_read = 1'b0;
            end
            chk("stream_fill_bound", {31'h0, (pipe.fill_words <= FW'(WPS))}, 32'h1);
            tick();
        end
        pipe.ep_read = 1'b0;
        test_clk     = 1'b0;
        repeat (8) tick();
        while (q.size() != 0) rd_chk("stream_tail");
        chk("stream_drain", {21'h0, pipe.fill_words}, 32'h0);

        // Set underflow, then reset in the middle of a sample write.
        pipe.ep_read = 1'b1;
        tick();
        pipe.ep_read = 1'b0;
        chk("underflow_set2", {31'h0, pipe.underflow}, 32'h1);
        sample_in = 32'h0BAD_F00D;
        test_clk  = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (pipe.fill_words == FW'(WPS - 1)) found = 1'b1;
        end
        chk("wr_hi_reached", {31'h0, found}, 32'h1);
        reset_global = 1'b1;
        test_clk     = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(negedge ti_clk);
        reset_global = 1'b0;
        q.delete();
        exp_ts = 16'h0;
        tick();
        chk_idle("post_reset");
        capture(32'h1357_9BDF, 1'b1);
        chk("post_reset_fill", {21'h0, pipe.fill_words}, WPS);
        for (int i = 0; i < WPS; i++) rd_chk("post_reset_word");
        chk("post_reset_drain", {21'h0, pipe.fill_words}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/waveform_to_pipe.md
WAVEFORM_TO_PIPE -- requirements
Module: waveform_to_pipe

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, 16-bit FIFO capacity; power of two.
REQ-002 Parameter BLOCK_WORDS, 256, BTPipeOut block length; power of two, at most DEPTH_WORDS.
REQ-003 Port ti_clk  in  1  host-interface clock; sole clock of the block.
REQ-004 Port reset_global  in  1  reset; asynchronous, active-high.
REQ-005 Port repop  in  1  synchronous clear of FIFO contents and flags, active-high, ti_clk domain.
REQ-006 Port test_clk  in  1  slow sample clock (sim_clk); asynchronous to ti_clk.
REQ-007 Port capture_en  in  1  level; samples are captured only while high.
REQ-008 Port sample_in  in  32  value captured on each test_clk rising edge.
REQ-009 Port ep_read  in  1  okBTPipeOut read strobe.
REQ-010 Port ep_datain  out  16  word presented to okBTPipeOut.
REQ-011 Port ep_ready  out  1  high when fill_words >= BLOCK_WORDS.
REQ-012 Port fill_words  out  $clog2(DEPTH_WORDS)+1  current FIFO occupancy in words.
REQ-013 Port overflow  out  1  sticky; a sample was dropped.
REQ-014 Port underflow  out  1  sticky; ep_read occurred while the FIFO was empty.

Function
REQ-015 test_clk SHALL pass through a 2-FF synchronizer into ti_clk; a synchronized rising edge produces a one-cycle cap_pulse.
REQ-016 On cap_pulse with capture_en high, sample_in SHALL be latched into a 32-bit hold register in the same cycle.
REQ-017 Write FSM states: IDLE, WR_LO, WR_HI. IDLE→WR_LO on an accepted capture; WR_LO writes hold[15:0]; WR_HI writes hold[31:16]; WR_HI→IDLE.
REQ-018 A capture SHALL be accepted only if free space >= words-per-sample at cap_pulse; otherwise no words are written and overflow SHALL set. A sample is never partially written.
REQ-019 cap_pulse arriving while the FSM is not IDLE SHALL be dropped and SHALL set overflow.
REQ-020 Read path: ep_datain SHALL always hold the word at the read pointer. On ep_read with FIFO non-empty, the read pointer advances and ep_datain SHALL show the next word by the following ti_clk edge.
REQ-021 On ep_read with FIFO empty: pointer unchanged, ep_datain = 16'h0000, underflow SHALL set.
REQ-022 A simultaneous write and read in one cycle SHALL leave fill_words unchanged.
REQ-023 Pointers SHALL wrap modulo DEPTH_WORDS; full and empty are distinguished by fill_words.
REQ-024 ep_ready SHALL be registered, updating one cycle after a fill_words change.
REQ-025 repop SHALL zero pointers, fill_words, overflow and underflow, and return the FSM to IDLE; it takes priority over a same-cycle capture or read.

Reset
REQ-026 On reset_global: FIFO empty, FSM IDLE, ep_datain=0, ep_ready=0, fill_words=0, overflow=0, underflow=0, synchronizer flops=0.
REQ-027 RAM contents SHALL NOT be reset; stale words are never presented because the read pointer is gated by fill_words.
REQ-028 reset_global asserted mid-sample SHALL abort the write with no half-sample visible after release.

Configuration
REQ-029 With WAVEFORM_TO_PIPE_TIMESTAMP_EN defined, each sample SHALL be preceded by a 16-bit sample index (WR_TS state before WR_LO; 3 words per sample). The index starts at 0 after reset or repop, increments on each accepted sample and wraps at 16'hFFFF→0.
REQ-030 Without WAVEFORM_TO_PIPE_TIMESTAMP_EN, there SHALL be 2 words per sample and no WR_TS state or index counter.

Structure
REQ-031 Package spike_pipe_pkg SHALL hold the write FSM state enum, WORDS_PER_SAMPLE (per macro), and the default DEPTH_WORDS and BLOCK_WORDS.
REQ-032 One sub-module, sync_edge_detect: 2-FF synchronizer plus rising-edge pulse, reused for test_clk.
REQ-033 The FIFO RAM SHALL be a single inferred simple dual-port block RAM; no vendor primitives.

Verification
REQ-034 Capture 32'h3F800000, then perform 2 ep_reads → ep_datain 16'h0000 then 16'h3F80; fill_words 2→0.
REQ-035 Capture 128 samples (BLOCK_WORDS=256) → ep_ready rises one cycle after fill_words=256; 256 reads return the data in order; ep_ready falls.
REQ-036 Fill to 1024 words, then one more test_clk edge → fill_words stays 1024, overflow=1, data unchanged; repop → overflow=0, fill_words=0.
REQ-037 ep_read on an empty FIFO → ep_datain=16'h0000, underflow=1, fill_words=0.
REQ-038 Continuous reads with captures every 8 ti_clk cycles → no loss, fill_words bounded; assert reset_global during WR_HI → all outputs match REQ-026.
REQ-039 With WAVEFORM_TO_PIPE_TIMESTAMP_EN defined, capture 3 samples → words read are 0,lo,hi,1,lo,hi,2,lo,hi.
